// File: rtl/ram2_arbiter_pkg.sv
// rtl/ram2_arbiter_pkg.sv - shared CPU definitions: word width, RAM controller states, pin decode
package ram2_arbiter_pkg;

  localparam int WORD_W  = 16;
  localparam int SRAM_AW = 18;

  typedef enum logic [2:0] {
    IDLE,
    IF_RD,
    MEM_RD,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD
  } ram_state_t;

  typedef struct packed {
    logic en_n;
    logic oe_n;
    logic we_n;
    logic drive;
  } pin_ctrl_t;

  // SRAM control levels wanted while the controller sits in state s
  function automatic pin_ctrl_t pins_for(ram_state_t s);
    pin_ctrl_t p;
    p = '{en_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, drive: 1'b0};
    case (s)
      IF_RD, MEM_RD: begin
        p.en_n = 1'b0;
        p.oe_n = 1'b0;
      end
      WR_SETUP, WR_HOLD: begin
        p.en_n  = 1'b0;
        p.drive = 1'b1;
      end
      WR_PULSE: begin
        p.en_n  = 1'b0;
        p.we_n  = 1'b0;
        p.drive = 1'b1;
      end
      default: ;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/ram2_arbiter_sram_port.sv
// rtl/ram2_arbiter_sram_port.sv - registered SRAM pin driver with tristate data buffer
module sram_port
  import ram2_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [SRAM_AW-1:0] addr_next,
  input  logic [WORD_W-1:0]  wdata_next,
  input  pin_ctrl_t          ctrl_next,
  output logic [SRAM_AW-1:0] addr,
  inout  wire  [WORD_W-1:0]  data,
  output logic               oe_n,
  output logic               we_n,
  output logic               en_n
);

  logic [WORD_W-1:0] wdata_q;
  logic              drive_q;

  // Reset is asynchronous so an interrupted write pulse is cut off at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr    <= '0;
      wdata_q <= '0;
      drive_q <= 1'b0;
      en_n    <= 1'b1;
      oe_n    <= 1'b1;
      we_n    <= 1'b1;
    end else begin
      if (load) begin
        addr    <= addr_next;
        wdata_q <= wdata_next;
      end
      en_n    <= ctrl_next.en_n;
      oe_n    <= ctrl_next.oe_n;
      we_n    <= ctrl_next.we_n;
      drive_q <= ctrl_next.drive;
    end
  end

  assign data = drive_q ? wdata_q : {WORD_W{1'bz}};

endmodule

// File: rtl/ram2_arbiter.sv
// rtl/ram2_arbiter.sv - RAM2 arbiter sharing one async SRAM between instruction fetch and MEM stage
module ram2_arbiter
  import ram2_arbiter_pkg::*;
#(
  parameter logic [1:0] ADDR_HI = 2'b00
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               if_req,
  input  logic [WORD_W-1:0]  if_addr,
  output logic [WORD_W-1:0]  if_data,
  output logic               if_valid,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [WORD_W-1:0]  mem_addr,
  input  logic [WORD_W-1:0]  mem_wdata,
  output logic [WORD_W-1:0]  mem_rdata,
  output logic               mem_done,
  output logic               stall_if_o,
  output logic [SRAM_AW-1:0] Ram2Addr,
  inout  wire  [WORD_W-1:0]  Ram2Data,
  output logic               Ram2OE,
  output logic               Ram2WE,
  output logic               Ram2EN
);

  ram_state_t         state, next_state;
  logic               load;
  logic               block_mem;
  logic [SRAM_AW-1:0] grant_addr;
  logic [WORD_W-1:0]  grant_wdata;

  // A finishing mem access must not be granted again before its requester drops it
  assign block_mem = (state == MEM_RD) || (state == WR_HOLD) || mem_done;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      if_data   <= '0;
      mem_rdata <= '0;
      if_valid  <= 1'b0;
      mem_done  <= 1'b0;
    end else begin
      state    <= next_state;
      if_valid <= (state == IF_RD);
      mem_done <= (state == MEM_RD) || (state == WR_HOLD);
      if (state == IF_RD)  if_data   <= Ram2Data;
      if (state == MEM_RD) mem_rdata <= Ram2Data;
    end
  end

  always_comb begin
    next_state  = IDLE;
    load        = 1'b0;
    grant_addr  = '0;
    grant_wdata = '0;
    unique case (state)
      WR_SETUP: next_state = WR_PULSE;
      WR_PULSE: next_state = WR_HOLD;
      default: begin
        // Access boundary: write beats read beats fetch
        if (mem_write && !block_mem) begin
          next_state  = WR_SETUP;
          load        = 1'b1;
          grant_addr  = {ADDR_HI, mem_addr};
          grant_wdata = mem_wdata;
        end else if (mem_read && !block_mem) begin
          next_state = MEM_RD;
          load       = 1'b1;
          grant_addr = {ADDR_HI, mem_addr};
        end else if (if_req) begin
          next_state = IF_RD;
          load       = 1'b1;
          grant_addr = {ADDR_HI, if_addr};
        end
      end
    endcase
  end

  assign stall_if_o = mem_read || mem_write || (state == MEM_RD) ||
                      (state == WR_SETUP) || (state == WR_PULSE) || (state == WR_HOLD);

  sram_port u_sram_port (
    .clk        (CLK),
    .rst_n      (RST),
    .load       (load),
    .addr_next  (grant_addr),
    .wdata_next (grant_wdata),
    .ctrl_next  (pins_for(next_state)),
    .addr       (Ram2Addr),
    .data       (Ram2Data),
    .oe_n       (Ram2OE),
    .we_n       (Ram2WE),
    .en_n       (Ram2EN)
  );

endmodule
